// File: rtl/adg732_scan_seq.sv
// adg732_scan_seq: channel scan sequencer feeding the ADG732 demux driver.
// Steps through 5-bit channel numbers according to a latched start/stop/mode
// configuration. Each channel is offered over a valid/ready handshake, and the
// sequencer then waits a programmable dwell before offering the next one.
//
// Ports
//   clk, rst_n       clock, async active-low reset
//   run              level; rising edge starts a scan, low requests stop
//   oneshot          1 = stop after one pass, 0 = loop
//   mode             00 up, 01 down, 10 ping-pong, 11 hold
//   start_ch/stop_ch first/last channel
//   dwell            cycles from handshake to next request (0 acts as 1)
//   ch_ready         driver accepts ch
//   ch_valid, ch     channel request
//   demux_en, busy   high while not idle
//   scan_done        one-cycle pulse at the end of each pass
module adg732_scan_seq #(
  parameter int DWELL_W = 24,
  parameter int NCH_W   = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  input  logic               oneshot,
  input  logic [1:0]         mode,
  input  logic [NCH_W-1:0]   start_ch,
  input  logic [NCH_W-1:0]   stop_ch,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               ch_ready,
  output logic               ch_valid,
  output logic [NCH_W-1:0]   ch,
  output logic               demux_en,
  output logic               busy,
  output logic               scan_done
);

  typedef enum logic [1:0] {IDLE, ISSUE, DWELL} state_t;

  localparam logic [1:0] M_UP = 2'b00, M_DN = 2'b01, M_PP = 2'b10;

  state_t             state, state_nxt;
  logic               run_q;
  logic [1:0]         mode_r;
  logic               oneshot_r;
  logic [NCH_W-1:0]   start_r, stop_r, ch_r, nxt_ch, lo, hi;
  logic [DWELL_W-1:0] dwell_r, cnt;
  logic               dir_r, nxt_dir, dir0, pass_end;
  logic               run_rise, hs, dwell_end;

  assign run_rise  = run & ~run_q;
  assign hs        = (state == ISSUE) & ch_ready;
  assign dwell_end = (state == DWELL) & (cnt == DWELL_W'(1));
  assign lo        = (start_r < stop_r) ? start_r : stop_r;
  assign hi        = (start_r < stop_r) ? stop_r  : start_r;
  // ping-pong leaves start_ch heading toward stop_ch (dir 1 = ascending)
  assign dir0      = (stop_r >= start_r);

  // Next channel and end-of-pass, evaluated from the last accepted channel.
  always_comb begin
    nxt_ch   = ch_r;
    nxt_dir  = dir_r;
    pass_end = 1'b0;
    case (mode_r)
      M_UP: begin
        pass_end = (ch_r == stop_r);
        nxt_ch   = ch_r + NCH_W'(1);
      end
      M_DN: begin
        pass_end = (ch_r == stop_r);
        nxt_ch   = ch_r - NCH_W'(1);
      end
      M_PP: begin
        if (lo == hi) begin
          pass_end = 1'b1;
        end else begin
          if (dir_r) begin
            if (ch_r == hi) begin
              nxt_ch  = ch_r - NCH_W'(1);
              nxt_dir = 1'b0;
            end else begin
              nxt_ch  = ch_r + NCH_W'(1);
            end
          end else begin
            if (ch_r == lo) begin
              nxt_ch  = ch_r + NCH_W'(1);
              nxt_dir = 1'b1;
            end else begin
              nxt_ch  = ch_r - NCH_W'(1);
            end
          end
          // the pass closes just before start_ch would be revisited
          pass_end = (nxt_ch == start_r);
        end
      end
      default: pass_end = 1'b1;   // hold: every request is a pass
    endcase
    if (pass_end) begin
      nxt_ch  = start_r;
      nxt_dir = dir0;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (run_rise) state_nxt = ISSUE;
      ISSUE:   if (ch_ready) state_nxt = DWELL;
      DWELL:   if (dwell_end)
                 state_nxt = (!run || (pass_end && oneshot_r)) ? IDLE : ISSUE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // run_q resets high so a run level already high at release is not an edge
      run_q     <= 1'b1;
      mode_r    <= '0;
      oneshot_r <= 1'b0;
      start_r   <= '0;
      stop_r    <= '0;
      dwell_r   <= DWELL_W'(1);
      ch_r      <= '0;
      dir_r     <= 1'b1;
      cnt       <= '0;
      scan_done <= 1'b0;
    end else begin
      run_q     <= run;
      // a pass that completes still reports done even if run has dropped
      scan_done <= dwell_end & pass_end;
      if (state == IDLE && run_rise) begin
        mode_r    <= mode;
        oneshot_r <= oneshot;
        start_r   <= start_ch;
        stop_r    <= stop_ch;
        dwell_r   <= (dwell == '0) ? DWELL_W'(1) : dwell;
        ch_r      <= start_ch;
        dir_r     <= (stop_ch >= start_ch);
      end
      if (hs)
        cnt <= dwell_r;
      else if (state == DWELL)
        cnt <= cnt - DWELL_W'(1);
      if (dwell_end) begin
        ch_r  <= nxt_ch;
        dir_r <= nxt_dir;
      end
    end
  end

  assign ch_valid = (state == ISSUE);
  assign busy     = (state != IDLE);
  assign demux_en = busy;
  assign ch       = ch_r;

endmodule

// File: tb/tb_adg732_scan_seq.sv
// Scoreboard bench for adg732_scan_seq: expected channels and pass ends are
// queued with each scan's stimulus and consumed by a negedge monitor at each
// handshake; the monitor also times the valid-low gap between requests.
module tb_adg732_scan_seq;
  logic        clk = 1'b0, rst_n = 1'b0, run = 1'b0, oneshot = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [4:0]  start_ch = '0, stop_ch = '0;
  logic [23:0] dwell = '0;
  logic        ch_ready = 1'b1;
  logic        ch_valid, demux_en, busy, scan_done;
  logic [4:0]  ch;

  adg732_scan_seq #(.DWELL_W(24), .NCH_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .oneshot(oneshot), .mode(mode),
    .start_ch(start_ch), .stop_ch(stop_ch), .dwell(dwell), .ch_ready(ch_ready),
    .ch_valid(ch_valid), .ch(ch), .demux_en(demux_en), .busy(busy),
    .scan_done(scan_done)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int exp_q[$];
  bit done_q[$];
  int hs_cnt = 0, done_cnt = 0, exp_dones = 0, exp_gap = 1, gap = 0;
  bit gap_arm = 1'b0, last_done = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  // monitor: sampled mid-cycle, inputs change only just after posedge
  always @(negedge clk) begin
    if (!rst_n) begin
      gap_arm   = 1'b0;
      last_done = 1'b0;
    end else begin
      if (scan_done) begin
        chk("done_pos", last_done, 1);
        last_done = 1'b0;
        done_cnt++;
      end
      if (gap_arm) begin
        if (ch_valid) begin
          chk("gap", gap, exp_gap);
          gap_arm = 1'b0;
        end else if (busy) gap++;
        else gap_arm = 1'b0;
      end
      if (ch_valid && ch_ready) begin
        hs_cnt++;
        if (exp_q.size() == 0) chk("extra_ch", ch, 32'hFFFF);
        else begin
          chk("ch", ch, exp_q.pop_front());
          last_done = done_q.pop_front();
        end
        gap_arm = 1'b1;
        gap     = 0;
      end
    end
  end

  task automatic clr();
    exp_q.delete(); done_q.delete();
    hs_cnt = 0; done_cnt = 0; exp_dones = 0;
  endtask

  task automatic push(input int c, input bit d);
    exp_q.push_back(c); done_q.push_back(d);
    if (d) exp_dones++;
  endtask

  task automatic start_scan(input logic [1:0] m, input logic [4:0] s, input logic [4:0] e,
                            input logic [23:0] d, input logic os);
    @(posedge clk); #1;
    run = 1'b0; mode = m; start_ch = s; stop_ch = e; dwell = d; oneshot = os;
    exp_gap = (d == 0) ? 1 : int'(d);
    @(posedge clk); #1;
    run = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic wait_hs(input int n, input int budget);
    for (int k = 0; k < budget && hs_cnt < n; k++) begin
      @(posedge clk); #1;
    end
    chk("hs_reach", hs_cnt, n);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    for (int k = 0; k < budget && busy; k++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_en"}, demux_en, 0);
    chk({tag, "_qleft"}, exp_q.size(), 0);
    chk({tag, "_dones"}, done_cnt, exp_dones);
  endtask

  initial begin
    bit stalled;
    #12;
    chk("rst_valid", ch_valid, 0);
    chk("rst_ch", ch, 0);
    chk("rst_busy", busy, 0);
    chk("rst_en", demux_en, 0);
    chk("rst_done", scan_done, 0);
    #11 rst_n = 1'b1;

    // up 3..6, dwell 4, one pass; config inputs scrambled after the start
    clr();
    push(3, 0); push(4, 0); push(5, 0); push(6, 1);
    start_scan(2'b00, 5'd3, 5'd6, 24'd4, 1'b1);
    start_ch = 5'd0; stop_ch = 5'd31; dwell = 24'd9; oneshot = 1'b0; mode = 2'b10;
    wait_idle("up", 200);

    // up with wrap, dwell 0 acts as 1
    clr();
    push(30, 0); push(31, 0); push(0, 0); push(1, 1);
    start_scan(2'b00, 5'd30, 5'd1, 24'd0, 1'b1);
    wait_idle("wrap", 200);

    // ping-pong 2..4 looping, stopped during the 8th request's dwell
    clr();
    push(2, 0); push(3, 0); push(4, 0); push(3, 1);
    push(2, 0); push(3, 0); push(4, 0); push(3, 1);
    start_scan(2'b10, 5'd2, 5'd4, 24'd2, 1'b0);
    wait_hs(8, 300);
    run = 1'b0;
    wait_idle("pp", 200);

    // backpressure: channel 5 stalled for 7 cycles
    clr();
    push(4, 0); push(5, 0); push(6, 1);
    ch_ready = 1'b0;
    start_scan(2'b00, 5'd4, 5'd6, 24'd2, 1'b1);
    stalled = 1'b0;
    for (int k = 0; k < 100 && busy; k++) begin
      ch_ready = 1'b0;
      if (ch_valid) begin
        if (ch == 5'd5 && !stalled) begin
          stalled = 1'b1;
          for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            chk("bp_valid", ch_valid, 1);
            chk("bp_ch", ch, 5);
          end
        end
        ch_ready = 1'b1;
      end
      @(posedge clk); #1;
    end
    ch_ready = 1'b1;
    wait_idle("bp", 200);

    // abort: run drops while channel 11 is pending
    clr();
    push(10, 0); push(11, 0);
    ch_ready = 1'b0;
    start_scan(2'b00, 5'd10, 5'd20, 24'd3, 1'b0);
    ch_ready = 1'b1;
    @(posedge clk); #1;
    ch_ready = 1'b0;
    start_ch = 5'd25;
    for (int k = 0; k < 20 && !ch_valid; k++) begin
      @(posedge clk); #1;
    end
    run = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("abort_hold", ch_valid, 1);
    end
    ch_ready = 1'b1;
    wait_idle("abort", 200);

    // reset in the middle of a dwell, run left high across release
    clr();
    push(0, 0);
    start_scan(2'b00, 5'd0, 5'd31, 24'd20, 1'b0);
    repeat (6) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", ch_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_en", demux_en, 0);
    chk("mid_rst_ch", ch, 0);
    chk("mid_rst_done", scan_done, 0);
    chk("mid_rst_qleft", exp_q.size(), 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("rel_busy", busy, 0);
    chk("rel_valid", ch_valid, 0);

    // hold on channel 9: every request is a pass
    clr();
    push(9, 1); push(9, 1); push(9, 1); push(9, 1);
    start_scan(2'b11, 5'd9, 5'd2, 24'd3, 1'b0);
    wait_hs(4, 200);
    run = 1'b0;
    wait_idle("hold", 200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
